core_sequencer: RTL and testbench

Multi-cycle control FSM for the core. It generates the 3-bit `state` consumed by the decoder and the other datapath stages, and handshakes with instruction and data memory. It also qualifies PC and register-file writes, and handles halt, illegal-instruction and memory-timeout conditions. It sits between the memory interfaces and the decoder/ALU/register file; exactly one instruction is in flight at a time.

---
 rtl/core_sequencer_if.sv | 30 +++
 rtl/core_sequencer.sv | 119 +++++++++++
 tb/tb_core_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Handshake/control bundle between core_sequencer and memories, decoder and datapath.
// The master side is the sequencer; the slave side is the surrounding core.
interface core_sequencer_if;
   logic [2:0]  state;
   logic        imem_req;
   logic        imem_ack;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        is_load;
   logic        is_store;
   logic        rd_nz;
   logic        illegal;
   logic        halt_req;
   logic        resume;
   logic        pc_we;
   logic        rf_we;
   logic [31:0] instret;
   logic [1:0]  err_code;

   modport master (
      output state, imem_req, dmem_req, dmem_we, pc_we, rf_we, instret, err_code,
      input  imem_ack, dmem_ack, is_load, is_store, rd_nz, illegal, halt_req, resume
   );

   modport slave (
      input  state, imem_req, dmem_req, dmem_we, pc_we, rf_we, instret, err_code,
      output imem_ack, dmem_ack, is_load, is_store, rd_nz, illegal, halt_req, resume
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/write sequencing with
// memory timeouts, halt/resume, sticky error reporting and retirement count.
module core_sequencer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rstn,
   core_sequencer_if.master bus
);

   localparam int unsigned STATE_W   = 3;
   localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
   localparam int unsigned INSTRET_W = 32;
   localparam int unsigned ERR_W     = 2;

   localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
   localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
   localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
   localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
   localparam logic [STATE_W-1:0] S_WRITE  = 3'd4;
   localparam logic [STATE_W-1:0] S_HALTED = 3'd5;
   localparam logic [STATE_W-1:0] S_ERROR  = 3'd6;

   localparam logic [ERR_W-1:0] E_IMEM    = 2'd1;
   localparam logic [ERR_W-1:0] E_DMEM    = 2'd2;
   localparam logic [ERR_W-1:0] E_ILLEGAL = 2'd3;

   logic [STATE_W-1:0]   state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 halt_pend_q, halt_pend_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;
   logic [ERR_W-1:0]     err_q, err_d;
   logic                 timeout_c;

   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State register and bookkeeping flops
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_FETCH;
         cnt_q       <= '0;
         halt_pend_q <= 1'b0;
         instret_q   <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         halt_pend_q <= halt_pend_d;
         instret_q   <= instret_d;
         err_q       <= err_d;
      end
   end

   // Next-state, wait counter, halt pending and retirement logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      halt_pend_d = halt_pend_q;
      instret_d   = instret_q;
      err_d       = err_q;

      case (state_q)
         S_FETCH: begin
            if (bus.imem_ack) begin
               state_d = S_DECODE;
            end else if (timeout_c) begin
               state_d = S_ERROR;
               err_d   = E_IMEM;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (bus.illegal) begin
               state_d = S_ERROR;
               err_d   = E_ILLEGAL;
            end else if (bus.is_load || bus.is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               state_d = S_WRITE;
            end else if (timeout_c) begin
               state_d = S_ERROR;
               err_d   = E_DMEM;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: begin
            instret_d = instret_q + INSTRET_W'(1);
            state_d   = (halt_pend_q || bus.halt_req) ? S_HALTED : S_FETCH;
         end
         S_HALTED: begin
            if (bus.resume) state_d = S_FETCH;
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase

      // Entering HALTED consumes the pending request, even one arriving this cycle
      if (bus.halt_req && (state_q != S_HALTED) && (state_q != S_ERROR)) halt_pend_d = 1'b1;
      if ((state_d == S_HALTED) && (state_q != S_HALTED)) halt_pend_d = 1'b0;
   end

   assign bus.state    = state_q;
   assign bus.imem_req = (state_q == S_FETCH);
   assign bus.dmem_req = (state_q == S_MEM);
   assign bus.dmem_we  = (state_q == S_MEM) && bus.is_store;
   assign bus.pc_we    = (state_q == S_WRITE);
   assign bus.rf_we    = (state_q == S_WRITE) && bus.rd_nz && !bus.is_store;
   assign bus.instret  = instret_q;
   assign bus.err_code = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a vector table for normal instruction flow
// plus hand-written sequences for timeouts, illegal, reset mid-MEM and instret wrap.
module tb_core_sequencer;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_bad;

   core_sequencer_if sif ();

   core_sequencer #(.TIMEOUT(16)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ia, da, ld, st, rd, ill, hr, rs;
      logic [2:0]  s;
      logic        pc, rf;
      logic [31:0] ir;
      logic [1:0]  ec;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic ia, da, ld, st, rd, ill, hr, rs,
                               input logic [2:0] s, input logic pc, rf,
                               input logic [31:0] ir, input logic [1:0] ec);
      vec_t v;
      v.ia = ia; v.da = da; v.ld = ld; v.st = st; v.rd = rd; v.ill = ill;
      v.hr = hr; v.rs = rs; v.s = s; v.pc = pc; v.rf = rf; v.ir = ir; v.ec = ec;
      return v;
   endfunction

   task automatic set_in(input logic ia, da, ld, st, rd, ill, hr, rs);
      sif.imem_ack = ia; sif.dmem_ack = da; sif.is_load = ld; sif.is_store = st;
      sif.rd_nz = rd; sif.illegal = ill; sif.halt_req = hr; sif.resume = rs;
   endtask

   function automatic logic [63:0] outs();
      return {22'd0, sif.state, sif.imem_req, sif.dmem_req, sif.dmem_we,
              sif.pc_we, sif.rf_we, sif.err_code, sif.instret};
   endfunction

   // Request strobes expected from the state the vector names
   function automatic logic [63:0] exp_pack(input logic [2:0] s, input logic st,
                                            input logic pc, rf, input logic [1:0] ec,
                                            input logic [31:0] ir);
      logic ireq, dreq, dwe;
      ireq = (s == 3'd0);
      dreq = (s == 3'd3);
      dwe  = (s == 3'd3) && st;
      return {22'd0, s, ireq, dreq, dwe, pc, rf, ec, ir};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      set_in(0,0,0,0,0,0,0,0);
      #1;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rstn  = 1'b0;
      set_in(0,0,0,0,0,0,0,0);

      //       ia da ld st rd il hr rs   s  pc rf ir ec
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,0,0,0,0));  // ALU instruction
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd1,0,0,0,0));
      vq.push_back(mk(0,0,0,0,1,0,0,0, 3'd2,0,0,0,0));
      vq.push_back(mk(0,0,0,0,1,0,0,0, 3'd4,1,1,0,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd0,0,0,1,0));
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,0,0,1,0));  // store, 3 MEM cycles
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd1,0,0,1,0));
      vq.push_back(mk(0,0,0,1,1,0,0,0, 3'd2,0,0,1,0));
      vq.push_back(mk(0,0,0,1,1,0,0,0, 3'd3,0,0,1,0));
      vq.push_back(mk(0,0,0,1,1,0,0,0, 3'd3,0,0,1,0));
      vq.push_back(mk(0,1,0,1,1,0,0,0, 3'd3,0,0,1,0));
      vq.push_back(mk(0,0,0,1,1,0,0,0, 3'd4,1,0,1,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd0,0,0,2,0));
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,0,0,2,0));  // load, same-cycle ack
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd1,0,0,2,0));
      vq.push_back(mk(0,0,1,0,1,0,0,0, 3'd2,0,0,2,0));
      vq.push_back(mk(0,1,1,0,1,0,0,0, 3'd3,0,0,2,0));
      vq.push_back(mk(0,0,1,0,1,0,0,0, 3'd4,1,1,2,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd0,0,0,3,0));
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,0,0,3,0));  // halt_req in DECODE
      vq.push_back(mk(0,0,0,0,0,0,1,0, 3'd1,0,0,3,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd2,0,0,3,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd4,1,0,3,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd5,0,0,4,0));
      vq.push_back(mk(0,0,0,0,0,0,1,0, 3'd5,0,0,4,0));  // ignored while HALTED
      vq.push_back(mk(0,0,0,0,0,0,0,1, 3'd5,0,0,4,0));
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,0,0,4,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd1,0,0,4,0));
      vq.push_back(mk(0,0,0,0,1,0,0,0, 3'd2,0,0,4,0));
      vq.push_back(mk(0,0,0,0,1,0,0,0, 3'd4,1,1,4,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd0,0,0,5,0));  // no stale halt
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,0,0,5,0));  // halt_req in WRITE
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd1,0,0,5,0));
      vq.push_back(mk(0,0,0,0,1,0,0,0, 3'd2,0,0,5,0));
      vq.push_back(mk(0,0,0,0,1,0,1,0, 3'd4,1,1,5,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd5,0,0,6,0));
      vq.push_back(mk(0,0,0,0,0,0,0,1, 3'd5,0,0,6,0));
      vq.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,0,0,6,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd1,0,0,6,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd2,0,0,6,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd4,1,0,6,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0, 3'd0,0,0,7,0));

      repeat (2) @(negedge clk);
      #1;
      check("reset_state", outs(), exp_pack(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
      rstn = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         set_in(vq[i].ia, vq[i].da, vq[i].ld, vq[i].st, vq[i].rd, vq[i].ill, vq[i].hr, vq[i].rs);
         #1;
         check($sformatf("vec%0d", i), outs(),
               exp_pack(vq[i].s, vq[i].st, vq[i].pc, vq[i].rf, vq[i].ec, vq[i].ir));
      end

      // imem timeout: 16 FETCH cycles then sticky ERROR
      do_reset();
      for (int i = 0; i < 16; i++) begin
         #1;
         check($sformatf("itmo_wait%0d", i), 64'({sif.state, sif.imem_req, sif.err_code}),
               64'({3'd0, 1'b1, 2'd0}));
         @(negedge clk);
      end
      #1;
      check("itmo_err", 64'({sif.state, sif.imem_req, sif.pc_we, sif.err_code}),
            64'({3'd6, 1'b0, 1'b0, 2'd1}));
      set_in(1,1,0,0,0,0,1,1);
      @(negedge clk);
      #1;
      check("itmo_sticky", 64'({sif.state, sif.err_code}), 64'({3'd6, 2'd1}));

      // ack on the 16th FETCH cycle wins over timeout
      do_reset();
      repeat (15) @(negedge clk);
      sif.imem_ack = 1'b1;
      #1;
      check("iack16_fetch", 64'({sif.state, sif.imem_req}), 64'({3'd0, 1'b1}));
      @(negedge clk);
      sif.imem_ack = 1'b0;
      #1;
      check("iack16_decode", 64'({sif.state, sif.err_code}), 64'({3'd1, 2'd0}));

      // illegal in EXEC -> ERROR code 3, no PC update
      @(negedge clk);
      set_in(0,0,0,0,1,1,0,0);
      #1;
      check("ill_exec", 64'({sif.state, sif.pc_we, sif.rf_we}), 64'({3'd2, 1'b0, 1'b0}));
      @(negedge clk);
      #1;
      check("ill_err", 64'({sif.state, sif.pc_we, sif.rf_we, sif.err_code, sif.instret}),
            64'({3'd6, 1'b0, 1'b0, 2'd3, 32'd0}));
      set_in(1,1,0,0,0,0,1,1);
      @(negedge clk);
      #1;
      check("ill_sticky", 64'({sif.state, sif.err_code}), 64'({3'd6, 2'd3}));

      // dmem timeout: 16 MEM cycles then ERROR code 2
      do_reset();
      sif.imem_ack = 1'b1;
      @(negedge clk);
      sif.imem_ack = 1'b0;
      @(negedge clk);
      sif.is_load = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         #1;
         check($sformatf("dtmo_wait%0d", i), 64'({sif.state, sif.dmem_req, sif.dmem_we}),
               64'({3'd3, 1'b1, 1'b0}));
         @(negedge clk);
      end
      #1;
      check("dtmo_err", 64'({sif.state, sif.dmem_req, sif.err_code}), 64'({3'd6, 1'b0, 2'd2}));

      // asynchronous reset in the middle of a store's MEM phase
      do_reset();
      sif.imem_ack = 1'b1;
      @(negedge clk);
      sif.imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      sif.imem_ack = 1'b1;
      @(negedge clk);
      sif.imem_ack = 1'b0;
      @(negedge clk);
      sif.is_store = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #3;
      check("rst_pre", 64'({sif.state, sif.dmem_req, sif.dmem_we, sif.instret}),
            64'({3'd3, 1'b1, 1'b1, 32'd1}));
      rstn = 1'b0;
      sif.imem_ack = 1'b1;
      #1;
      check("rst_mid_mem", outs(), exp_pack(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      set_in(0,0,0,0,0,0,0,0);
      #1;
      check("rst_ack_fetch", 64'({sif.state, sif.instret}), 64'({3'd1, 32'd0}));

      // instret wraps from all-ones to zero
      do_reset();
      force dut.instret_d = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.instret_d;
      @(negedge clk);
      #1;
      check("wrap_preload", 64'(sif.instret), 64'(32'hFFFF_FFFF));
      sif.imem_ack = 1'b1;
      @(negedge clk);
      sif.imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("wrap_write", 64'({sif.state, sif.pc_we, sif.instret}), 64'({3'd4, 1'b1, 32'hFFFF_FFFF}));
      @(negedge clk);
      #1;
      check("wrap_zero", 64'({sif.state, sif.instret}), 64'({3'd0, 32'd0}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
